division_seq: RTL and testbench

//  Sequential radix-2 restoring divider: 2W-bit unsigned dividend / W-bit divisor
//  -> W-bit quotient and W-bit remainder. Inverse companion of the 16x16 Booth

---
 rtl/arith_pkg.sv | 18 +
 rtl/div_step.sv | 24 ++
 rtl/division_seq.sv | 121 ++++++++++++
 tb/tb_division_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider state encoding, default width and
// counter sizing helper.
package arith_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Bits needed to count WIDTH-1 down to 0; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left by the
// next dividend bit and subtract the divisor when it fits.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {r_in[WIDTH-1:0], q_msb};
        // r_in[WIDTH] set means the true shifted value already exceeds any divisor.
        q_bit   = r_in[WIDTH] | (shifted >= {1'b0, divisor});
        r_out   = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/division_seq.sv
// Sequential radix-2 restoring divider, 2W/W -> W quotient and W remainder,
// one quotient bit per clock with valid/ready handshakes on both sides.
module division_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e         state_q, state_d;
    logic [WIDTH:0]     r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     step_r;
    logic               step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (r_q),
        .q_msb   (q_q[WIDTH-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = {1'b0, dividend[WIDTH-1:0]};
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        // Quotient would need more than WIDTH bits.
                        q_d     = '1;
                        r_d     = '0;
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        r_d     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        q_d     = dividend[WIDTH-1:0];
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d = step_r;
                q_d = {q_q[WIDTH-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quot        = q_q;
    assign rem         = r_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_division_seq.sv
// Scenario-based bench for division_seq: directed corner cases, backpressure,
// mid-operation reset and randomised multiply-then-divide round trips.
module tb_division_seq;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dbz;
        logic         ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           div_by_zero;
    logic           overflow;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    exp_t sb[$];

    division_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t m;
        m = '0;
        if (dvs == '0) begin
            m.quot = '1;
            m.rem  = dvd[W-1:0];
            m.dbz  = 1'b1;
        end else if (dvd[2*W-1:W] >= dvs) begin
            m.quot = '1;
            m.ovf  = 1'b1;
        end else begin
            m.quot = W'(dvd / {{W{1'b0}}, dvs});
            m.rem  = W'(dvd % {{W{1'b0}}, dvs});
        end
        return m;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input exp_t e);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            $display("FAIL send_in_ready: in_ready=%b required 1", in_ready);
        end
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_edge = cyc;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    // Latency counts the accept cycle as cycle k, so out_valid seen right
    // after the accept edge is latency 1.
    task automatic collect(input string name, input int exp_lat, input int hold);
        exp_t e;
        int   n = 0;
        int   lat;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        lat = cyc - acc_edge + 1;
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        passes++;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL %s_scoreboard: result with no pending expectation", name);
            return;
        end
        e = sb.pop_front();
        if (exp_lat > 0) begin
            checks++;
            if (lat !== exp_lat) $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
            else passes++;
        end
        checks++;
        if (quot !== e.quot) $display("FAIL %s_quot: got %h required %h", name, quot, e.quot);
        else passes++;
        checks++;
        if (rem !== e.rem) $display("FAIL %s_rem: got %h required %h", name, rem, e.rem);
        else passes++;
        checks++;
        if (div_by_zero !== e.dbz) $display("FAIL %s_dbz: got %b required %b", name, div_by_zero, e.dbz);
        else passes++;
        checks++;
        if (overflow !== e.ovf) $display("FAIL %s_ovf: got %b required %b", name, overflow, e.ovf);
        else passes++;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 32'h0000_0050;
            divisor  = 16'd3;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.quot || rem !== e.rem
                || div_by_zero !== e.dbz || overflow !== e.ovf)
                $display("FAIL %s_hold%0d: ov=%b ir=%b q=%h r=%h required ov=1 ir=0 q=%h r=%h",
                         name, i, out_valid, in_ready, quot, rem, e.quot, e.rem);
            else passes++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_handshake: ov=%b ir=%b required ov=0 ir=1", name, out_valid, in_ready);
        else passes++;
        $display("txn %s: quot=%h rem=%h dbz=%b ovf=%b lat=%0d", name, quot, rem, div_by_zero, overflow, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_hs: ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
        else passes++;
        checks++;
        if (quot !== '0 || rem !== '0) $display("FAIL reset_data: q=%h r=%h required 0 0", quot, rem);
        else passes++;
        checks++;
        if (div_by_zero !== 1'b0 || overflow !== 1'b0) $display("FAIL reset_flags: dbz=%b ovf=%b required 0 0", div_by_zero, overflow);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        send(32'h0000_0064, 16'd7, '{16'd14, 16'd2, 1'b0, 1'b0});
        collect("basic_100_7", 17, 0);
        send(32'hFFFE_0001, 16'hFFFF, '{16'hFFFF, 16'h0000, 1'b0, 1'b0});
        collect("max_valid", 17, 0);
        send(32'h0000_1234, 16'd0, '{16'hFFFF, 16'h1234, 1'b1, 1'b0});
        collect("div_zero", 1, 0);
        send(32'h0001_0000, 16'd1, '{16'hFFFF, 16'h0000, 1'b0, 1'b1});
        collect("overflow", 1, 0);
        send(32'hFFFF_FFFF, 16'd0, '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0});
        collect("zero_wins", 1, 0);
        send(32'hFFFE_FFFF, 16'hFFFF, '{16'hFFFF, 16'hFFFE, 1'b0, 1'b0});
        collect("max_rem", 17, 0);
    endtask

    task automatic test_backpressure();
        send(32'h0000_0064, 16'd7, '{16'd14, 16'd2, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            dividend = 32'h0000_0050;
            divisor  = 16'd3;
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_run_ready%0d: got %b required 0", i, in_ready);
            else passes++;
        end
        in_valid = 1'b0;
        collect("backpressure", 17, 5);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_idle: ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
        else passes++;
        send(32'h0000_0050, 16'd3, '{16'd26, 16'd2, 1'b0, 1'b0});
        collect("after_bp", 17, 0);
    endtask

    task automatic test_reset_mid_run();
        send(32'h0000_0064, 16'd7, '{16'd14, 16'd2, 1'b0, 1'b0});
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_hs: ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
        else passes++;
        checks++;
        if (quot !== '0 || rem !== '0 || div_by_zero !== 1'b0 || overflow !== 1'b0)
            $display("FAIL midrst_data: q=%h r=%h dbz=%b ovf=%b required all 0", quot, rem, div_by_zero, overflow);
        else passes++;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h0000_0064, 16'd7, '{16'd14, 16'd2, 1'b0, 1'b0});
        collect("post_reset", 17, 0);
    endtask

    task automatic test_random_roundtrip();
        logic [W-1:0]   a, b, r;
        logic [2*W-1:0] prod;
        for (int i = 0; i < 2000; i++) begin
            a    = W'($urandom);
            b    = W'($urandom_range(65535, 1));
            r    = W'($urandom_range(int'(b) - 1, 0));
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b} + {{W{1'b0}}, r};
            send(prod, b, '{a, r, 1'b0, 1'b0});
            collect("rand_mul", 17, (i % 8 == 0) ? int'($urandom_range(3, 0)) : 0);
        end
    endtask

    task automatic test_random_general();
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        exp_t           e;
        for (int i = 0; i < 200; i++) begin
            dvd = $urandom;
            dvs = (i % 10 == 0) ? '0 : W'($urandom);
            if (i % 3 == 0) dvd[2*W-1:W] = W'($urandom_range(3, 0));
            e = model(dvd, dvs);
            send(dvd, dvs, e);
            collect("rand_gen", (e.dbz || e.ovf) ? 1 : 17, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random_roundtrip();
        test_random_general();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
